ttt_turn_ctrl: RTL and testbench
================================

// Module: ttt_turn_ctrl
// PURPOSE
//  Holds the tic-tac-toe board, runs the player turn sequence and the per-turn BCD countdown.
//  Outputs feed the game-over checker: b0..b8, whos_turn, ten_digit and unit_digit.
//  The checker's 2-bit result comes back on game_end, and this block freezes play when it is non-zero.
// PARAMETERS
//  TICK_DIV   50_000_000  clk cycles per countdown second (>=2)
//  TURN_TEN   4'd3        BCD tens digit loaded at each turn start (0..9)
//  TURN_UNIT  4'd0        BCD units digit loaded at each turn start (0..9)
// PORTS
//  clk         in   1  system clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  start       in   1  1-cycle pulse: clear board and begin a new game
//  place_valid in   1  1-cycle pulse: current player requests cell_sel
//  cell_sel    in   4  target cell 0..8, row-major (b0 top-left)
//  game_end    in   2  from checker: 00 running, 01 P1 wins, 10 P2 wins
//  b0..b8      out  2  cell state: 00 empty, 01 P1, 10 P2
//  whos_turn   out  1  0 = P1 to move, 1 = P2 to move
//  ten_digit   out  4  BCD tens of remaining turn seconds
//  unit_digit  out  4  BCD units of remaining turn seconds
//  move_ack    out  1  1-cycle pulse: move accepted
//  move_err    out  1  1-cycle pulse: move rejected
//  playing     out  1  high while in PLAY
//  draw        out  1  high in OVER when the board filled with game_end==00
// BEHAVIOUR
//  Reset values:
//   - state IDLE; all cells 00; whos_turn 0; digits TURN_TEN/TURN_UNIT.
//   - prescaler 0; move count 0; move_ack, move_err, playing and draw all 0.
//  FSM IDLE -> PLAY -> OVER. All outputs are registered.
//  start:
//   - Highest priority, in any state.
//   - Next cycle: board cleared, whos_turn 0, digits reloaded, prescaler 0, move count 0, draw 0, state PLAY.
//  PLAY, place_valid asserted:
//   - Accepted when cell_sel<=8, the target cell is 00 and the digits are not 00/00.
//   - On accept, next edge:
//     - cell <= 01 when whos_turn=0, 10 when whos_turn=1; whos_turn toggles.
//     - Digits reload; prescaler clears; move count +1; move_ack=1 for one cycle.
//   - Otherwise: move_err=1 for one cycle and no other state changes.
//  Countdown:
//   - In PLAY the prescaler counts 0..TICK_DIV-1; at wrap, BCD-decrement the digits.
//   - Decrement rule: units>0 -> units-1; else tens-1, units=9.
//   - At 00/00 the digits hold and the prescaler stops. Timeout is the checker's decision.
//  Simultaneous accepted move and prescaler wrap: the move wins, the digits reload and the decrement is dropped.
//  PLAY -> OVER:
//   - When game_end != 00 is sampled.
//   - Or one cycle after the 9th accepted move, if game_end is still 00; draw=1.
//  OVER:
//   - Board, whos_turn and digits are frozen.
//   - place_valid produces move_err. Only start leaves OVER.
//  IDLE: place_valid produces move_err; the timer does not run.
//  Reset mid-game: immediate return to reset values. No pending pulse survives.
//  Widths: cell_sel values 9..15 are rejected. The move count is 4 bits and saturates at 9.
// STRUCTURE
//  Package ttt_pkg:
//   - Cell codes CELL_EMPTY=2'b00, CELL_P1=2'b01, CELL_P2=2'b10.
//   - Game-end codes GE_RUN, GE_P1, GE_P2.
//   - State encoding ST_IDLE, ST_PLAY, ST_OVER.
//  Sub-module ttt_bcd_turn_timer:
//   - Contains the prescaler plus the two BCD digits.
//   - Inputs: load, run.
//   - Outputs: ten_digit, unit_digit, zero.
//  Top level: FSM, 9x2-bit board register file, move counter, ack/err pulse generation.
// TESTING (TICK_DIV=4, TURN_TEN=0, TURN_UNIT=3 unless noted)
//  1. Reset, then start.
//     -> All b* 00, whos_turn 0, digits 0/3, playing 1 on the next cycle.
//  2. Moves at cells 4, 0, 4.
//     -> b4=01, b0=10, third move gives move_err.
//     -> whos_turn 0,1,0; b4 is unchanged.
//  3. No moves.
//     -> Digits 03->02->01->00 at 4-cycle intervals, then hold 00.
//     -> A move then gives move_err.
//  4. Accepted move on the same cycle as the prescaler wrap.
//     -> Digits reload to 03; no 02 is seen.
//  5. Drive game_end=01 after 5 moves.
//     -> playing 0; further moves give move_err; the board is frozen.
//     -> start clears the board and sets playing 1.
//  6. Nine alternating moves with game_end held at 00.
//     -> draw 1, state OVER.
//     -> Assert rst_n=0 mid-game in a separate run: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared codes for the tic-tac-toe turn controller: cell contents, checker result and FSM states.
package ttt_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_P1    = 2'b01,
    CELL_P2    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    GE_RUN = 2'b00,
    GE_P1  = 2'b01,
    GE_P2  = 2'b10
  } game_end_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  localparam int         NUM_CELLS = 9;
  localparam logic [3:0] CELL_LAST = 4'd8;
  localparam logic [3:0] MOVES_MAX = 4'd9;

  // Mark written into the board for the player whose turn it is.
  function automatic logic [1:0] player_mark(input logic turn);
    return turn ? CELL_P2 : CELL_P1;
  endfunction

endpackage

// File: rtl/ttt_turn_ctrl_if.sv
// Move request / response handshake between the player front end and the turn controller.
interface ttt_turn_ctrl_if;
  logic       start;
  logic       place_valid;
  logic [3:0] cell_sel;
  logic       move_ack;
  logic       move_err;

  modport master (
    output start,
    output place_valid,
    output cell_sel,
    input  move_ack,
    input  move_err
  );

  modport slave (
    input  start,
    input  place_valid,
    input  cell_sel,
    output move_ack,
    output move_err
  );
endinterface

// File: rtl/ttt_bcd_turn_timer.sv
// Per-turn countdown: a TICK_DIV prescaler driving a two-digit BCD down-counter that stops at 00.
module ttt_bcd_turn_timer #(
  parameter int         TICK_DIV  = 50_000_000,
  parameter logic [3:0] TURN_TEN  = 4'd3,
  parameter logic [3:0] TURN_UNIT = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       run,
  output logic [3:0] ten_digit,
  output logic [3:0] unit_digit,
  output logic       zero
);

  localparam int             PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;

  assign zero = (ten_digit == 4'd0) && (unit_digit == 4'd0);

  // load outranks a same-cycle wrap, so an accepted move drops the pending decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      ten_digit  <= TURN_TEN;
      unit_digit <= TURN_UNIT;
    end else if (load) begin
      presc      <= '0;
      ten_digit  <= TURN_TEN;
      unit_digit <= TURN_UNIT;
    end else if (run && !zero) begin
      if (presc == PRESC_LAST) begin
        presc <= '0;
        if (unit_digit != 4'd0) begin
          unit_digit <= unit_digit - 4'd1;
        end else begin
          ten_digit  <= ten_digit - 4'd1;
          unit_digit <= 4'd9;
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/ttt_turn_ctrl.sv
// Tic-tac-toe turn controller: board storage, player alternation, move validation and turn timer.
module ttt_turn_ctrl
  import ttt_pkg::*;
#(
  parameter int         TICK_DIV  = 50_000_000,
  parameter logic [3:0] TURN_TEN  = 4'd3,
  parameter logic [3:0] TURN_UNIT = 4'd0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ttt_turn_ctrl_if.slave        bus,
  input  logic [1:0]            game_end,
  output logic [1:0]            b0,
  output logic [1:0]            b1,
  output logic [1:0]            b2,
  output logic [1:0]            b3,
  output logic [1:0]            b4,
  output logic [1:0]            b5,
  output logic [1:0]            b6,
  output logic [1:0]            b7,
  output logic [1:0]            b8,
  output logic                  whos_turn,
  output logic [3:0]            ten_digit,
  output logic [3:0]            unit_digit,
  output logic                  playing,
  output logic                  draw
);

  state_t          state, state_nxt;
  logic [8:0][1:0] board;
  logic [3:0]      move_cnt;
  logic            ack_q, err_q, playing_q, draw_q;
  logic            ack_nxt, err_nxt, playing_nxt, draw_nxt;
  logic [1:0]      cell_cur;
  logic            running, accept, reject;
  logic            timer_zero;

  // Read the addressed cell; out-of-range selects read as empty but are rejected below.
  always_comb begin
    cell_cur = CELL_EMPTY;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (bus.cell_sel == 4'(i)) cell_cur = board[i];
    end
  end

  assign running = (state == ST_PLAY) && (game_end == GE_RUN);
  assign accept  = !bus.start && bus.place_valid && running &&
                   (bus.cell_sel <= CELL_LAST) && (cell_cur == CELL_EMPTY) && !timer_zero;
  assign reject  = !bus.start && bus.place_valid && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      playing_q <= 1'b0;
      draw_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      ack_q     <= ack_nxt;
      err_q     <= err_nxt;
      playing_q <= playing_nxt;
      draw_q    <= draw_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.start) begin
      state_nxt = ST_PLAY;
    end else begin
      case (state)
        ST_PLAY: if ((game_end != GE_RUN) || (move_cnt == MOVES_MAX)) state_nxt = ST_OVER;
        default: state_nxt = state;
      endcase
    end
  end

  // Output values are computed one cycle ahead so every output leaves a flop.
  always_comb begin
    ack_nxt     = accept;
    err_nxt     = reject;
    playing_nxt = (state_nxt == ST_PLAY);
    draw_nxt    = draw_q;
    if (bus.start) begin
      draw_nxt = 1'b0;
    end else if ((state == ST_PLAY) && (game_end == GE_RUN) && (move_cnt == MOVES_MAX)) begin
      draw_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board     <= '0;
      whos_turn <= 1'b0;
      move_cnt  <= 4'd0;
    end else if (bus.start) begin
      board     <= '0;
      whos_turn <= 1'b0;
      move_cnt  <= 4'd0;
    end else if (accept) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        if (bus.cell_sel == 4'(i)) board[i] <= player_mark(whos_turn);
      end
      whos_turn <= ~whos_turn;
      if (move_cnt != MOVES_MAX) move_cnt <= move_cnt + 4'd1;
    end
  end

  ttt_bcd_turn_timer #(
    .TICK_DIV  (TICK_DIV),
    .TURN_TEN  (TURN_TEN),
    .TURN_UNIT (TURN_UNIT)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (bus.start | accept),
    .run        (running),
    .ten_digit  (ten_digit),
    .unit_digit (unit_digit),
    .zero       (timer_zero)
  );

  assign bus.move_ack = ack_q;
  assign bus.move_err = err_q;
  assign playing      = playing_q;
  assign draw         = draw_q;

  assign b0 = board[0];
  assign b1 = board[1];
  assign b2 = board[2];
  assign b3 = board[3];
  assign b4 = board[4];
  assign b5 = board[5];
  assign b6 = board[6];
  assign b7 = board[7];
  assign b8 = board[8];

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Directed bench for ttt_turn_ctrl with a 4-cycle tick and a 3-second turn.
module tb_ttt_turn_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] game_end;
  logic [1:0] b0, b1, b2, b3, b4, b5, b6, b7, b8;
  logic       whos_turn, playing, draw;
  logic [3:0] ten_digit, unit_digit;
  logic [17:0] board_all;
  int n_checks;
  int n_fail;

  ttt_turn_ctrl_if bus();

  ttt_turn_ctrl #(
    .TICK_DIV  (4),
    .TURN_TEN  (4'd0),
    .TURN_UNIT (4'd3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .game_end   (game_end),
    .b0         (b0),
    .b1         (b1),
    .b2         (b2),
    .b3         (b3),
    .b4         (b4),
    .b5         (b5),
    .b6         (b6),
    .b7         (b7),
    .b8         (b8),
    .whos_turn  (whos_turn),
    .ten_digit  (ten_digit),
    .unit_digit (unit_digit),
    .playing    (playing),
    .draw       (draw)
  );

  assign board_all = {b8, b7, b6, b5, b4, b3, b2, b1, b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic do_move(input logic [3:0] c, output logic a, output logic e);
    @(negedge clk);
    bus.place_valid = 1'b1;
    bus.cell_sel    = c;
    @(posedge clk);
    #1;
    a = bus.move_ack;
    e = bus.move_err;
    bus.place_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({board_all, whos_turn, ten_digit, unit_digit} !== {18'h0, 1'b0, 4'd0, 4'd3}) begin
      n_fail++;
      $display("FAIL reset_state: got board=%h turn=%b digits=%0d%0d expected board=0 turn=0 digits=03",
               board_all, whos_turn, ten_digit, unit_digit);
    end
    n_checks++;
    if ({playing, draw, bus.move_ack, bus.move_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got play/draw/ack/err=%b expected 0000",
               {playing, draw, bus.move_ack, bus.move_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_move();
    logic a, e;
    do_move(4'd0, a, e);
    n_checks++;
    if ({a, e, board_all} !== {2'b01, 18'h0}) begin
      n_fail++;
      $display("FAIL idle_move: got ack/err=%b board=%h expected 01 board=0", {a, e}, board_all);
    end
  endtask

  task automatic test_start();
    pulse_start();
    n_checks++;
    if ({playing, board_all, whos_turn, ten_digit, unit_digit} !== {1'b1, 18'h0, 1'b0, 4'd0, 4'd3}) begin
      n_fail++;
      $display("FAIL start: got play=%b board=%h turn=%b digits=%0d%0d expected play=1 board=0 turn=0 digits=03",
               playing, board_all, whos_turn, ten_digit, unit_digit);
    end
  endtask

  task automatic test_moves();
    logic a, e;
    do_move(4'd4, a, e);
    n_checks++;
    if ({a, e, board_all, whos_turn} !== {2'b10, 18'h00100, 1'b1}) begin
      n_fail++;
      $display("FAIL move_c4: got ack/err=%b board=%h turn=%b expected 10 board=00100 turn=1",
               {a, e}, board_all, whos_turn);
    end
    do_move(4'd0, a, e);
    n_checks++;
    if ({a, e, board_all, whos_turn} !== {2'b10, 18'h00102, 1'b0}) begin
      n_fail++;
      $display("FAIL move_c0: got ack/err=%b board=%h turn=%b expected 10 board=00102 turn=0",
               {a, e}, board_all, whos_turn);
    end
    do_move(4'd4, a, e);
    n_checks++;
    if ({a, e, board_all, whos_turn} !== {2'b01, 18'h00102, 1'b0}) begin
      n_fail++;
      $display("FAIL move_occupied: got ack/err=%b board=%h turn=%b expected 01 board=00102 turn=0",
               {a, e}, board_all, whos_turn);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.move_ack, bus.move_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL err_one_cycle: got ack/err=%b expected 00", {bus.move_ack, bus.move_err});
    end
    do_move(4'd9, a, e);
    n_checks++;
    if ({a, e, board_all, whos_turn} !== {2'b01, 18'h00102, 1'b0}) begin
      n_fail++;
      $display("FAIL move_c9: got ack/err=%b board=%h turn=%b expected 01 board=00102 turn=0",
               {a, e}, board_all, whos_turn);
    end
    do_move(4'd15, a, e);
    n_checks++;
    if ({a, e, board_all} !== {2'b01, 18'h00102}) begin
      n_fail++;
      $display("FAIL move_c15: got ack/err=%b board=%h expected 01 board=00102", {a, e}, board_all);
    end
  endtask

  task automatic test_countdown();
    logic a, e;
    logic [7:0] exp_d;
    pulse_start();
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      exp_d = (k >= 12) ? 8'h00 : {4'd0, 4'(3 - k / 4)};
      n_checks++;
      if ({ten_digit, unit_digit} !== exp_d) begin
        n_fail++;
        $display("FAIL countdown_k%0d: got digits=%h expected %h", k, {ten_digit, unit_digit}, exp_d);
      end
    end
    do_move(4'd0, a, e);
    n_checks++;
    if ({a, e, board_all, ten_digit, unit_digit} !== {2'b01, 18'h0, 8'h00}) begin
      n_fail++;
      $display("FAIL timeout_move: got ack/err=%b board=%h digits=%h expected 01 board=0 digits=00",
               {a, e}, board_all, {ten_digit, unit_digit});
    end
  endtask

  task automatic test_move_at_wrap();
    logic a, e;
    pulse_start();
    repeat (3) @(posedge clk);
    do_move(4'd2, a, e);
    n_checks++;
    if ({a, e, ten_digit, unit_digit} !== {2'b10, 8'h03}) begin
      n_fail++;
      $display("FAIL wrap_move: got ack/err=%b digits=%h expected 10 digits=03", {a, e}, {ten_digit, unit_digit});
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ten_digit, unit_digit} !== 8'h03) begin
      n_fail++;
      $display("FAIL wrap_hold: got digits=%h expected 03", {ten_digit, unit_digit});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({ten_digit, unit_digit} !== 8'h02) begin
      n_fail++;
      $display("FAIL wrap_next_tick: got digits=%h expected 02", {ten_digit, unit_digit});
    end
  endtask

  task automatic test_game_end();
    logic a, e;
    logic ok;
    pulse_start();
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      do_move(4'(c), a, e);
      if ({a, e} !== 2'b10) ok = 1'b0;
    end
    n_checks++;
    if ({ok, board_all, whos_turn} !== {1'b1, 18'h00199, 1'b1}) begin
      n_fail++;
      $display("FAIL five_moves: got all_acked=%b board=%h turn=%b expected 1 board=00199 turn=1",
               ok, board_all, whos_turn);
    end
    @(negedge clk);
    game_end = 2'b01;
    @(posedge clk);
    #1;
    n_checks++;
    if (playing !== 1'b0) begin
      n_fail++;
      $display("FAIL game_end_stop: got playing=%b expected 0", playing);
    end
    do_move(4'd5, a, e);
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if ({a, e, board_all, whos_turn, ten_digit, unit_digit, draw} !== {2'b01, 18'h00199, 1'b1, 8'h03, 1'b0}) begin
      n_fail++;
      $display("FAIL over_frozen: got ack/err=%b board=%h turn=%b digits=%h draw=%b expected 01 00199 1 03 0",
               {a, e}, board_all, whos_turn, {ten_digit, unit_digit}, draw);
    end
    @(negedge clk);
    game_end = 2'b00;
    pulse_start();
    n_checks++;
    if ({playing, board_all, whos_turn} !== {1'b1, 18'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL restart: got play=%b board=%h turn=%b expected 1 0 0", playing, board_all, whos_turn);
    end
  endtask

  task automatic test_draw();
    logic a, e;
    logic ok;
    pulse_start();
    ok = 1'b1;
    for (int c = 0; c < 9; c++) begin
      do_move(4'(c), a, e);
      if ({a, e} !== 2'b10) ok = 1'b0;
    end
    n_checks++;
    if ({ok, board_all, whos_turn, playing, draw} !== {1'b1, 18'h19999, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL nine_moves: got all_acked=%b board=%h turn=%b play=%b draw=%b expected 1 19999 1 1 0",
               ok, board_all, whos_turn, playing, draw);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({playing, draw} !== 2'b01) begin
      n_fail++;
      $display("FAIL draw_over: got play/draw=%b expected 01", {playing, draw});
    end
    do_move(4'd0, a, e);
    n_checks++;
    if ({a, e, board_all} !== {2'b01, 18'h19999}) begin
      n_fail++;
      $display("FAIL draw_move: got ack/err=%b board=%h expected 01 19999", {a, e}, board_all);
    end
  endtask

  task automatic test_async_reset();
    logic a, e;
    pulse_start();
    do_move(4'd4, a, e);
    @(negedge clk);
    bus.place_valid = 1'b1;
    bus.cell_sel    = 4'd5;
    @(posedge clk);
    #1;
    bus.place_valid = 1'b0;
    n_checks++;
    if ({bus.move_ack, board_all} !== {1'b1, 18'h00900}) begin
      n_fail++;
      $display("FAIL pre_reset_move: got ack=%b board=%h expected 1 00900", bus.move_ack, board_all);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({board_all, whos_turn, ten_digit, unit_digit, playing, draw, bus.move_ack, bus.move_err} !==
        {18'h0, 1'b0, 8'h03, 4'b0000}) begin
      n_fail++;
      $display("FAIL async_reset: got board=%h turn=%b digits=%h play/draw/ack/err=%b expected 0 0 03 0000",
               board_all, whos_turn, {ten_digit, unit_digit}, {playing, draw, bus.move_ack, bus.move_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({playing, bus.move_ack} !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_idle: got play/ack=%b expected 00", {playing, bus.move_ack});
    end
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    game_end        = 2'b00;
    bus.start       = 1'b0;
    bus.place_valid = 1'b0;
    bus.cell_sel    = 4'd0;
    test_reset();
    test_idle_move();
    test_start();
    test_moves();
    test_countdown();
    test_move_at_wrap();
    test_game_end();
    test_draw();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
